// File: rtl/health_monitor_scheduler_pkg.sv
// healthcare_pkg: shared types and constants for the health monitor scheduler.
//   state_t          : scan FSM states
//   CH_*             : channel indices (also the alarmCode values)
//   PRIORITY_ORDER   : packed list of channels, slot 0 = highest priority
//   highest_pending  : picks the highest-priority set bit of a pending vector
package healthcare_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      SAMPLE,
      WAIT
   } state_t;

   localparam logic [1:0] CH_PRESSURE = 2'd0;
   localparam logic [1:0] CH_BLOOD    = 2'd1;
   localparam logic [1:0] CH_FALL     = 2'd2;
   localparam logic [1:0] CH_TEMP     = 2'd3;

   // Slot 0 (bits 1:0) is served first: fall > pressure > temperature > blood.
   localparam logic [7:0] PRIORITY_ORDER = {CH_BLOOD, CH_TEMP, CH_PRESSURE, CH_FALL};

   function automatic logic [1:0] highest_pending(input logic [3:0] pending);
      logic [1:0] code;
      code = '0;
      // Walk from lowest to highest priority so the last hit is the winner.
      for (int unsigned i = 0; i < 4; i++) begin
         if (pending[PRIORITY_ORDER[(3 - i) * 2 +: 2]]) begin
            code = PRIORITY_ORDER[(3 - i) * 2 +: 2];
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/health_monitor_scheduler_if.sv
// Alarm handshake between the scheduler and the downstream alert logic.
//   alarmValid : an alarm is presented (driven by master)
//   alarmCode  : channel index of the presented alarm (driven by master)
//   alarmAck   : consumer accepts the presented alarm (driven by slave)
interface health_monitor_scheduler_if;
   logic       alarmValid;
   logic [1:0] alarmCode;
   logic       alarmAck;

   modport master (output alarmValid, output alarmCode, input alarmAck);
   modport slave  (input alarmValid, input alarmCode, output alarmAck);
endinterface

// File: rtl/health_monitor_scheduler_debouncer.sv
// abnormality_debouncer: per-channel saturating debounce counter.
//   clk, resetN : clock, async active-low reset
//   sample      : one-cycle strobe, flag is only looked at while high
//   flag        : raw detector flag
//   abnormal    : registered debounced state
//   rise        : registered one-cycle pulse on a 0->1 change of abnormal
module abnormality_debouncer #(
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic clk,
   input  logic resetN,
   input  logic sample,
   input  logic flag,
   output logic abnormal,
   output logic rise
);

   localparam int unsigned CW = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt;
      if (sample) begin
         if (!flag) begin
            cnt_next = '0;
         end else if (cnt != CNT_MAX) begin
            cnt_next = cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cnt      <= '0;
         abnormal <= 1'b0;
         rise     <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         rise <= 1'b0;
         if (sample) begin
            abnormal <= (cnt_next == CNT_MAX);
            rise     <= (cnt_next == CNT_MAX) && !abnormal;
         end
      end
   end

endmodule

// File: rtl/health_monitor_scheduler.sv
// health_monitor_scheduler: round-robin scan of four detector flags with
// debounce, sticky pending alarms and a priority arbiter on a valid/ack bus.
//   clk, resetN            : clock, async active-low reset
//   enable                 : scanning requested
//   presureAbnormality ... : channel 0..3 detector flags
//   sensorLoad             : one-hot load strobe, bit = channel
//   abnormalFlags          : debounced state per channel
//   scanDone               : one-cycle pulse in the last SAMPLE of a round
//   alarm                  : alarm handshake (master side)
module health_monitor_scheduler
   import healthcare_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned DEBOUNCE      = 3,
   parameter int unsigned SAMPLE_PERIOD = 16
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic                       enable,
   input  logic                       presureAbnormality,
   input  logic                       bloodAbnormality,
   input  logic                       fallDetected,
   input  logic                       temperatureAbnormality,
   output logic [3:0]                 sensorLoad,
   output logic [3:0]                 abnormalFlags,
   output logic                       scanDone,
   health_monitor_scheduler_if.master alarm
);

   localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned PW = $clog2(SAMPLE_PERIOD + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);

   state_t        state;
   logic [1:0]    ch;
   logic [SW-1:0] settle_cnt;
   logic [PW-1:0] period_cnt;
   logic [3:0]    flags;
   logic [3:0]    sample_vec;
   logic [3:0]    rise_vec;
   logic [3:0]    pending;
   logic [3:0]    clear_vec;

   always_comb begin
      flags             = '0;
      flags[CH_PRESSURE] = presureAbnormality;
      flags[CH_BLOOD]    = bloodAbnormality;
      flags[CH_FALL]     = fallDetected;
      flags[CH_TEMP]     = temperatureAbnormality;
   end

   assign sample_vec = (state == SAMPLE) ? (4'b0001 << ch) : '0;

   for (genvar g = 0; g < 4; g++) begin : g_deb
      abnormality_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb (
         .clk      (clk),
         .resetN   (resetN),
         .sample   (sample_vec[g]),
         .flag     (flags[g]),
         .abnormal (abnormalFlags[g]),
         .rise     (rise_vec[g])
      );
   end

   // sensorLoad and scanDone are loaded on the transition into the state
   // that shows them, so they are plain registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= IDLE;
         ch         <= '0;
         settle_cnt <= '0;
         period_cnt <= '0;
         sensorLoad <= '0;
         scanDone   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  ch         <= '0;
                  sensorLoad <= 4'b0001;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               sensorLoad <= '0;
               settle_cnt <= '0;
               state      <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  scanDone <= (ch == 2'd3);
                  state    <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            SAMPLE: begin
               scanDone <= 1'b0;
               if (ch == 2'd3) begin
                  period_cnt <= '0;
                  state      <= WAIT;
               end else begin
                  ch         <= ch + 2'd1;
                  sensorLoad <= 4'b0001 << (ch + 2'd1);
                  state      <= LOAD;
               end
            end
            WAIT: begin
               if (period_cnt == PERIOD_LAST) begin
                  if (enable) begin
                     ch         <= '0;
                     sensorLoad <= 4'b0001;
                     state      <= LOAD;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  period_cnt <= period_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign clear_vec = (alarm.alarmValid && alarm.alarmAck) ? (4'b0001 << alarm.alarmCode) : '0;

   // Arbiter only chooses while idle, so the presented code stays frozen and
   // valid is always low for at least one cycle after an ack.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pending          <= '0;
         alarm.alarmValid <= 1'b0;
         alarm.alarmCode  <= '0;
      end else begin
         pending <= (pending & ~clear_vec) | rise_vec;
         if (alarm.alarmValid) begin
            if (alarm.alarmAck) begin
               alarm.alarmValid <= 1'b0;
            end
         end else if (pending != '0) begin
            alarm.alarmCode  <= highest_pending(pending);
            alarm.alarmValid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_health_monitor_scheduler.sv
// Scoreboard bench for health_monitor_scheduler with default parameters.
// Cycle n is the clock period following the n-th rising edge after enable
// is first seen (LOAD of channel 0 is cycle 1).
module tb_health_monitor_scheduler;

   localparam int SETTLE = 2;
   localparam int PERIOD = 16;
   localparam int SLOT   = SETTLE + 2;
   localparam int ROUND  = 4 * SLOT + PERIOD;

   typedef struct {
      int cycle;
      int value;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetN;
   logic       enable;
   logic       presure, blood, fall, temp;
   logic [3:0] sensorLoad;
   logic [3:0] abnormalFlags;
   logic       scanDone;

   health_monitor_scheduler_if alarm_bus ();

   health_monitor_scheduler #(
      .SETTLE_CYCLES (SETTLE),
      .DEBOUNCE      (3),
      .SAMPLE_PERIOD (PERIOD)
   ) dut (
      .clk                    (clk),
      .resetN                 (resetN),
      .enable                 (enable),
      .presureAbnormality     (presure),
      .bloodAbnormality       (blood),
      .fallDetected           (fall),
      .temperatureAbnormality (temp),
      .sensorLoad             (sensorLoad),
      .abnormalFlags          (abnormalFlags),
      .scanDone               (scanDone),
      .alarm                  (alarm_bus)
   );

   always #5 clk = ~clk;

   exp_t alarm_q[$];
   exp_t load_q[$];
   exp_t scan_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   prev_valid;
   bit   watch_loads;
   bit   auto_ack;

   task automatic check(input string tag, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   // Model expected slot timing: load of channel c in round r, and its SAMPLE cycle.
   function automatic int load_cycle(input int r, input int c);
      return 1 + r * ROUND + c * SLOT;
   endfunction

   function automatic int sample_cycle(input int r, input int c);
      return load_cycle(r, c) + SETTLE + 1;
   endfunction

   task automatic push(inout exp_t q[$], input int cycle, input int value);
      exp_t e;
      e.cycle = cycle;
      e.value = value;
      q.push_back(e);
   endtask

   task automatic observe();
      exp_t e;
      if (alarm_bus.alarmAck) begin
         check("valid_drop_after_ack", int'(alarm_bus.alarmValid), 0);
         alarm_bus.alarmAck = 1'b0;
      end
      if (alarm_bus.alarmValid && !prev_valid) begin
         if (alarm_q.size() == 0) begin
            check("unexpected_alarm_cycle", cyc, -1);
         end else begin
            e = alarm_q.pop_front();
            check("alarm_cycle", cyc, e.cycle);
            check("alarm_code", int'(alarm_bus.alarmCode), e.value);
         end
         if (auto_ack) alarm_bus.alarmAck = 1'b1;
      end
      prev_valid = alarm_bus.alarmValid;
      if (alarm_q.size() != 0 && cyc > alarm_q[0].cycle) begin
         e = alarm_q.pop_front();
         check("alarm_missing", cyc, e.cycle);
      end
      if (watch_loads) begin
         if (sensorLoad != 4'b0000) begin
            if (load_q.size() == 0) begin
               check("unexpected_load", int'(sensorLoad), 0);
            end else begin
               e = load_q.pop_front();
               check("load_cycle", cyc, e.cycle);
               check("load_value", int'(sensorLoad), e.value);
            end
         end else if (load_q.size() != 0 && cyc >= load_q[0].cycle) begin
            e = load_q.pop_front();
            check("load_missing", cyc, e.cycle);
         end
         if (scanDone) begin
            if (scan_q.size() == 0) begin
               check("unexpected_scan_done", cyc, -1);
            end else begin
               e = scan_q.pop_front();
               check("scan_done_cycle", cyc, e.cycle);
            end
         end else if (scan_q.size() != 0 && cyc >= scan_q[0].cycle) begin
            e = scan_q.pop_front();
            check("scan_done_missing", cyc, e.cycle);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      observe();
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic do_ack();
      alarm_bus.alarmAck = 1'b1;
      tick();
   endtask

   task automatic apply_reset();
      resetN             = 1'b0;
      enable             = 1'b0;
      presure            = 1'b0;
      blood              = 1'b0;
      fall               = 1'b0;
      temp               = 1'b0;
      alarm_bus.alarmAck = 1'b0;
      alarm_q.delete();
      load_q.delete();
      scan_q.delete();
      watch_loads = 1'b0;
      auto_ack    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetN = 1'b1;
      check("rst_sensor_load", int'(sensorLoad), 0);
      check("rst_abnormal", int'(abnormalFlags), 0);
      check("rst_scan_done", int'(scanDone), 0);
      check("rst_alarm_valid", int'(alarm_bus.alarmValid), 0);
      check("rst_alarm_code", int'(alarm_bus.alarmCode), 0);
      @(negedge clk);
      check("idle_sensor_load", int'(sensorLoad), 0);
      enable     = 1'b1;
      cyc        = 0;
      prev_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      check({name, "_alarm_left"}, alarm_q.size(), 0);
      check({name, "_load_left"}, load_q.size(), 0);
      check({name, "_scan_left"}, scan_q.size(), 0);
   endtask

   initial begin
      // Idle scan: load/scanDone timing across two rounds, no alarms.
      apply_reset();
      watch_loads = 1'b1;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++)
            if (r == 0 || c < 2) push(load_q, load_cycle(r, c), 1 << c);
      push(scan_q, sample_cycle(0, 3), 1);
      run_to(load_cycle(1, 1) + 2);
      check("quiet_abnormal", int'(abnormalFlags), 0);
      drain("quiet");

      // Fall held: third sample declares abnormal, alarm two cycles later.
      apply_reset();
      fall     = 1'b1;
      auto_ack = 1'b1;
      push(alarm_q, sample_cycle(2, 2) + 3, 2);
      run_to(sample_cycle(2, 2));
      check("fall_before_third", int'(abnormalFlags), 0);
      tick();
      check("fall_after_third", int'(abnormalFlags), 4'b0100);
      run_to(sample_cycle(3, 3) + 4);
      check("fall_flags_held", int'(abnormalFlags), 4'b0100);
      drain("fall");

      // Fall for two rounds then clear: counter restarts from zero.
      apply_reset();
      fall     = 1'b1;
      auto_ack = 1'b1;
      run_to(50);
      fall = 1'b0;
      run_to(80);
      fall = 1'b1;
      push(alarm_q, sample_cycle(5, 2) + 3, 2);
      run_to(sample_cycle(4, 2) + 1);
      check("fall_restart_no_flag", int'(abnormalFlags), 0);
      run_to(sample_cycle(5, 2) + 1);
      check("fall_restart_flag", int'(abnormalFlags), 4'b0100);
      run_to(sample_cycle(5, 2) + 8);
      drain("restart");

      // Pressure then temperature, no ack until later.
      apply_reset();
      presure = 1'b1;
      temp    = 1'b1;
      push(alarm_q, sample_cycle(2, 0) + 3, 0);
      run_to(90);
      check("p_t_flags", int'(abnormalFlags), 4'b1001);
      check("p_t_held_valid", int'(alarm_bus.alarmValid), 1);
      check("p_t_held_code", int'(alarm_bus.alarmCode), 0);
      push(alarm_q, 92, 3);
      do_ack();
      run_to(92);
      do_ack();
      run_to(100);
      drain("p_t");

      // Pressure presented; fall goes pending and must wait for the ack.
      apply_reset();
      presure = 1'b1;
      push(alarm_q, sample_cycle(2, 0) + 3, 0);
      run_to(20);
      fall = 1'b1;
      run_to(sample_cycle(3, 2) + 4);
      check("frozen_valid", int'(alarm_bus.alarmValid), 1);
      check("frozen_code", int'(alarm_bus.alarmCode), 0);
      run_to(115);
      push(alarm_q, 117, 2);
      auto_ack = 1'b1;
      do_ack();
      run_to(125);
      drain("frozen");

      // Enable dropped mid-round: round finishes, then FSM idles.
      apply_reset();
      watch_loads = 1'b1;
      for (int c = 0; c < 4; c++) push(load_q, load_cycle(0, c), 1 << c);
      push(scan_q, sample_cycle(0, 3), 1);
      run_to(6);
      enable = 1'b0;
      run_to(load_cycle(1, 1) + 4);
      drain("drop_enable");

      // Async reset during SETTLE with an alarm presented.
      apply_reset();
      fall = 1'b1;
      push(alarm_q, sample_cycle(2, 2) + 3, 2);
      run_to(sample_cycle(2, 2) + 3);
      check("pre_reset_valid", int'(alarm_bus.alarmValid), 1);
      check("pre_reset_flags", int'(abnormalFlags), 4'b0100);
      #2;
      resetN = 1'b0;
      #1;
      check("async_rst_valid", int'(alarm_bus.alarmValid), 0);
      check("async_rst_code", int'(alarm_bus.alarmCode), 0);
      check("async_rst_flags", int'(abnormalFlags), 0);
      check("async_rst_load", int'(sensorLoad), 0);
      check("async_rst_scan", int'(scanDone), 0);
      drain("async_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/health_monitor_scheduler.md
# health_monitor_scheduler

Sequences the first-phase healthcare detectors (pressure, blood, fall, temperature). It scans the four channels in a fixed round, strobing each sensor load, waiting for the combinational detector to settle, and sampling its flag. Each flag is debounced, and new abnormalities are latched as sticky pending alarms. Pending alarms are presented one at a time, in priority order, on a valid/ack handshake to the downstream alert logic.

## Interface
- SETTLE_CYCLES, 2: wait cycles between load strobe and sample; must be ≥1.
- DEBOUNCE, 3: consecutive abnormal samples needed to declare a channel abnormal; must be ≥1.
- SAMPLE_PERIOD, 16: idle cycles between scan rounds; must be ≥1.
- clk  in  1  system clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- enable  in  1  scanning requested.
- presureAbnormality  in  1  channel 0 detector flag.
- bloodAbnormality  in  1  channel 1 detector flag.
- fallDetected  in  1  channel 2 detector flag.
- temperatureAbnormality  in  1  channel 3 detector flag.
- sensorLoad  out  4  one-hot load strobe to the sensor input registers; bit = channel.
- abnormalFlags  out  4  debounced abnormal state per channel.
- scanDone  out  1  one-cycle pulse at the end of each round.
- alarmValid  out  1  an alarm is presented.
- alarmCode  out  2  channel index of the presented alarm.
- alarmAck  in  1  consumer accepts the presented alarm.

## Operation
- The FSM has these states: IDLE, LOAD, SETTLE, SAMPLE, WAIT. The current channel index is ch (2 bits).
- IDLE: if enable=1, set ch←0 and go to LOAD.
- LOAD (1 cycle): sensorLoad[ch]=1. Next state is SETTLE, with the settle counter set to 0.
- SETTLE: hold for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle): capture flag[ch] and update debounce counter cnt[ch]:
  - flag=1: cnt←min(cnt+1, DEBOUNCE).
  - flag=0: cnt←0.
  - abnormalFlags[ch]←(new cnt==DEBOUNCE).
  - A 0→1 transition of abnormalFlags[ch] sets pending[ch].
  - If ch<3: ch←ch+1 and go to LOAD.
  - If ch==3: pulse scanDone in this cycle and go to WAIT with the period counter at 0.
- WAIT: hold for SAMPLE_PERIOD cycles. Then, if enable=1, set ch←0 and go to LOAD; otherwise go to IDLE.
- Dropping enable mid-round does not abort the round. The round completes, and the FSM enters IDLE at the end of WAIT.
- Debounce counters and abnormalFlags keep their values in IDLE.
- Alarm arbiter, when alarmValid=0 and pending≠0:
  - Load alarmCode with the highest-priority pending channel. Priority order: fall(2) > pressure(0) > temperature(3) > blood(1).
  - Assert alarmValid on the next cycle.
- While alarmValid=1, alarmCode is frozen. A newly set higher-priority pending bit waits.
- In a cycle where alarmValid&&alarmAck, clear pending[alarmCode] and drop alarmValid. alarmValid stays low for at least one cycle before the next alarm is presented.
- If the same pending bit is set and cleared in the same cycle, the set wins.
- alarmAck while alarmValid=0 is ignored.

## Timing
- Reset values:
  - state=IDLE, ch=0.
  - All counters, cnt[], and pending are 0.
  - sensorLoad, abnormalFlags, scanDone, alarmValid, alarmCode are all 0.
- All outputs are registered or decoded from registered state. No input→output combinational path.
- enable high at edge k puts the FSM in LOAD during cycle k+1.
- Per-channel slot length is SETTLE_CYCLES+2 cycles. Round length is 4·(SETTLE_CYCLES+2)+SAMPLE_PERIOD cycles, which is 32 with the defaults.
- Detector flags are sampled only in SAMPLE. Flag glitches in other states are ignored.
- A SAMPLE edge that sets pending produces alarmValid high two cycles later, provided the arbiter was idle.
- Counter widths:
  - Settle counter: $clog2(SETTLE_CYCLES+1).
  - Period counter: $clog2(SAMPLE_PERIOD+1).
  - cnt: $clog2(DEBOUNCE+1).
  - cnt saturates at DEBOUNCE and never wraps.
- Reset asserted mid-operation returns everything to reset values immediately. Pending alarms are lost.

## Structure
- Package healthcare_pkg holds:
  - The state enum (IDLE, LOAD, SETTLE, SAMPLE, WAIT).
  - Channel index constants CH_PRESSURE=0, CH_BLOOD=1, CH_FALL=2, CH_TEMP=3.
  - The priority order constant.
- Sub-module abnormality_debouncer, instantiated ×4:
  - Inputs: sample strobe, flag.
  - Outputs: abnormal, rise pulse.
  - Parameter: DEBOUNCE.
- The FSM and arbiter live in the top-level module.

## Test plan
- Reset, enable=1, all flags 0 → sensorLoad shows 0001, 0010, 0100, 1000 at cycles 1, 5, 9, 13; scanDone pulses at cycle 16; next 0001 appears at cycle 33; no alarm.
- fallDetected held 1 → abnormalFlags[2] rises in the third round's fall SAMPLE; alarmValid=1 with alarmCode=2 two cycles later; alarmAck pulse → alarmValid low the next cycle.
- fallDetected=1 for two rounds, then 0 → abnormalFlags[2] stays 0 and cnt resets; no alarm.
- Pressure and temperature become abnormal in the same round with no ack → alarmCode=0 presented first; after ack and one idle cycle, alarmCode=3 is presented.
- Pressure alarm valid and unacked while fall goes pending → alarmCode stays 0 until ack, then 2 is presented.
- enable dropped mid-round → remaining channels still sampled, scanDone pulses, FSM reaches IDLE after WAIT; resetN pulsed during SETTLE → all outputs 0 asynchronously.
